// File: rtl/sobel_frame_sequencer_if.sv
// Memory request bus and window/magnitude exchange between the Sobel frame
// sequencer and its environment (pixel memory plus gradient datapath).
interface sobel_frame_sequencer_if #(
    parameter int ADDR_W = 16
) ();
    logic              start;
    logic              mem_busy;
    logic [7:0]        mem_rdata;
    logic [7:0]        g;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ren;
    logic              mem_wen;
    logic [7:0]        mem_wdata;
    logic [71:0]       window;
    logic              win_valid;
    logic              busy;
    logic              done;

    modport master (
        input  start, mem_busy, mem_rdata, g,
        output mem_addr, mem_ren, mem_wen, mem_wdata, window, win_valid, busy, done
    );

    modport slave (
        output start, mem_busy, mem_rdata, g,
        input  mem_addr, mem_ren, mem_wen, mem_wdata, window, win_valid, busy, done
    );
endinterface

// File: rtl/sobel_frame_sequencer.sv
// Walks a 3x3 window over the input image, fetching nine taps per output
// position, and writes the saturated gradient magnitude to the output region.
module sobel_frame_sequencer #(
    parameter int IMG_W    = 16,
    parameter int IMG_H    = 16,
    parameter int ADDR_W   = 16,
    parameter int IN_BASE  = 0,
    parameter int OUT_BASE = 16'h8000
) (
    input  logic                     clk,
    input  logic                     n_rst,
    sobel_frame_sequencer_if.master  bus
);
    localparam int DATA_W = 8;
    localparam int CW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 3);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 3);

    typedef enum logic [2:0] {IDLE, READ, WAIT, CALC, WRITE, DONE} state_t;

    state_t                        state, state_n;
    logic [RW-1:0]                 row, row_n;
    logic [CW-1:0]                 col, col_n;
    logic [3:0]                    tap, tap_n;
    logic                          cap_vld;
    logic [3:0]                    cap_tap;
    logic [8:0][DATA_W-1:0]        win;
    logic [DATA_W-1:0]             wdata;
    logic                          ren, wen;
    logic [ADDR_W-1:0]             addr, rd_addr, wr_addr;
    logic [3:0]                    pos;
    logic                          rd_acc;

    // Tap index -> {row offset, column offset} within the 3x3 window.
    function automatic logic [3:0] tap_pos(input logic [3:0] t);
        case (t)
            4'd0: tap_pos = {2'd0, 2'd0};
            4'd1: tap_pos = {2'd0, 2'd1};
            4'd2: tap_pos = {2'd0, 2'd2};
            4'd3: tap_pos = {2'd1, 2'd0};
            4'd4: tap_pos = {2'd1, 2'd1};
            4'd5: tap_pos = {2'd1, 2'd2};
            4'd6: tap_pos = {2'd2, 2'd0};
            4'd7: tap_pos = {2'd2, 2'd1};
            4'd8: tap_pos = {2'd2, 2'd2};
            default: tap_pos = 4'd0;
        endcase
    endfunction

    assign pos     = tap_pos(tap);
    assign rd_addr = ADDR_W'(IN_BASE) + (ADDR_W'(row) + ADDR_W'(pos[3:2])) * ADDR_W'(IMG_W)
                   + ADDR_W'(col) + ADDR_W'(pos[1:0]);
    assign wr_addr = ADDR_W'(OUT_BASE) + ADDR_W'(row) * ADDR_W'(IMG_W - 2) + ADDR_W'(col);
    assign rd_acc  = (state == READ) && !bus.mem_busy;

    always_comb begin
        state_n = state;
        row_n   = row;
        col_n   = col;
        tap_n   = tap;
        ren     = 1'b0;
        wen     = 1'b0;
        addr    = '0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = READ;
                    row_n   = '0;
                    col_n   = '0;
                    tap_n   = '0;
                end
            end
            READ: begin
                ren  = 1'b1;
                addr = rd_addr;
                if (!bus.mem_busy) begin
                    if (tap == 4'd8) begin
                        tap_n   = '0;
                        state_n = WAIT;
                    end else begin
                        tap_n = tap + 4'd1;
                    end
                end
            end
            WAIT: state_n = CALC;
            CALC: state_n = WRITE;
            WRITE: begin
                wen  = 1'b1;
                addr = wr_addr;
                if (!bus.mem_busy) begin
                    if (row == LAST_ROW && col == LAST_COL) begin
                        state_n = DONE;
                    end else begin
                        state_n = READ;
                        tap_n   = '0;
                        if (col == LAST_COL) begin
                            col_n = '0;
                            row_n = row + 1'b1;
                        end else begin
                            col_n = col + 1'b1;
                        end
                    end
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Read data lands one edge after its request was accepted, so the tap
    // index travels alongside in cap_tap.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state   <= IDLE;
            row     <= '0;
            col     <= '0;
            tap     <= '0;
            cap_vld <= 1'b0;
            cap_tap <= '0;
            win     <= '0;
            wdata   <= '0;
        end else begin
            state   <= state_n;
            row     <= row_n;
            col     <= col_n;
            tap     <= tap_n;
            cap_vld <= rd_acc;
            cap_tap <= tap;
            if (cap_vld) win[cap_tap] <= bus.mem_rdata;
            if (state == CALC) wdata <= bus.g;
        end
    end

    assign bus.mem_addr  = addr;
    assign bus.mem_ren   = ren;
    assign bus.mem_wen   = wen;
    assign bus.mem_wdata = wdata;
    assign bus.window    = win;
    assign bus.win_valid = (state == CALC);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Bench for the Sobel frame sequencer: behavioural memory and gradient stand-in,
// with every transaction checked against a frame-level expectation list.
module tb_sobel_frame_sequencer;
    localparam int W        = 5;
    localparam int H        = 4;
    localparam int OW       = W - 2;
    localparam int OH       = H - 2;
    localparam int NPIX     = OW * OH;
    localparam int IN_BASE  = 0;
    localparam int OUT_BASE = 16'h8000;

    logic clk = 1'b0;
    logic n_rst;
    int   total = 0;
    int   bad   = 0;

    logic [7:0]  img [0:255];
    logic [15:0] rq[$];
    logic [15:0] wq[$];
    logic [7:0]  dq[$];
    logic [71:0] winq[$];
    int          first_wdata;

    sobel_frame_sequencer_if #(.ADDR_W(16)) sif ();

    sobel_frame_sequencer #(
        .IMG_W(W), .IMG_H(H), .ADDR_W(16), .IN_BASE(IN_BASE), .OUT_BASE(OUT_BASE)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (sif.master)
    );

    always #5 clk = ~clk;

    // Sobel |gx|+|gy| saturated to 8 bits
    function automatic logic [7:0] grad(input logic [71:0] w);
        int p[9];
        int gx, gy, m;
        for (int i = 0; i < 9; i++) p[i] = int'(w[8*i +: 8]);
        gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
        gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
        m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (m > 255) ? 8'd255 : 8'(m);
    endfunction

    always_comb sif.g = grad(sif.window);

    always @(posedge clk) begin
        if (sif.mem_ren && !sif.mem_busy) sif.mem_rdata <= img[sif.mem_addr[7:0]];
        else                              sif.mem_rdata <= 8'($urandom);
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build_model();
        logic [71:0] w;
        int a;
        rq.delete(); wq.delete(); dq.delete(); winq.delete();
        for (int r = 0; r < OH; r++) begin
            for (int c = 0; c < OW; c++) begin
                for (int k = 0; k < 9; k++) begin
                    a = IN_BASE + (r + k / 3) * W + c + k % 3;
                    rq.push_back(16'(a));
                    w[8*k +: 8] = img[a & 255];
                end
                winq.push_back(w);
                wq.push_back(16'(OUT_BASE + r * OW + c));
                dq.push_back(grad(w));
            end
        end
    endtask

    task automatic run_frame(input int stall_pct, input bit hold);
        int done_k, stalls, first_win, first_wr;
        done_k = -1; stalls = 0; first_win = -1; first_wr = -1; first_wdata = -1;
        build_model();
        @(negedge clk);
        sif.start = 1'b1;
        sif.mem_busy = 1'b0;
        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk);
            sif.mem_busy = (stall_pct > 0) ? ($urandom_range(0, 99) < stall_pct) : 1'b0;
            if (!hold) sif.start = 1'($urandom_range(0, 1));
            #1;
            chk("ren_wen_excl", sif.mem_ren & sif.mem_wen, 0);
            if (sif.mem_ren) begin
                if (sif.mem_busy) stalls++;
                if (rq.size() == 0) chk("rd_extra", 1, 0);
                else begin
                    chk("rd_addr", sif.mem_addr, rq[0]);
                    if (!sif.mem_busy) void'(rq.pop_front());
                end
            end
            if (sif.win_valid) begin
                if (first_win < 0) first_win = k;
                if (winq.size() == 0) chk("win_extra", 1, 0);
                else chk("window", sif.window, winq.pop_front());
            end
            if (sif.mem_wen) begin
                if (sif.mem_busy) stalls++;
                if (first_wr < 0) first_wr = k;
                if (first_wdata < 0) first_wdata = int'(sif.mem_wdata);
                if (wq.size() == 0) chk("wr_extra", 1, 0);
                else begin
                    chk("wr_addr", sif.mem_addr, wq[0]);
                    chk("wr_data", sif.mem_wdata, dq[0]);
                    if (!sif.mem_busy) begin
                        void'(wq.pop_front());
                        void'(dq.pop_front());
                    end
                end
            end
            if (sif.done) begin
                done_k = k;
                break;
            end
        end
        chk("done_cycle", done_k, 12 * NPIX + 1 + stalls);
        chk("reads_left", rq.size(), 0);
        chk("writes_left", wq.size(), 0);
        chk("windows_left", winq.size(), 0);
        if (stall_pct == 0) begin
            chk("first_win_cycle", first_win, 11);
            chk("first_wr_cycle", first_wr, 12);
        end
        @(negedge clk);
        sif.start = hold;
        sif.mem_busy = 1'b0;
        #1;
        chk("idle_after_done", sif.busy, 0);
        chk("done_one_cycle", sif.done, 0);
        if (hold) begin
            @(negedge clk);
            #1;
            chk("relaunch_ren", sif.mem_ren, 1);
            chk("relaunch_addr", sif.mem_addr, IN_BASE);
        end
    endtask

    task automatic rand_img();
        for (int a = 0; a < 256; a++) img[a] = 8'($urandom);
    endtask

    initial begin
        int wcnt, dcnt;
        n_rst = 1'b0;
        sif.start = 1'b1;
        sif.mem_busy = 1'b0;
        for (int a = 0; a < 256; a++) img[a] = 8'(a);

        // reset held with start high
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_busy", sif.busy, 0);
        chk("rst_done", sif.done, 0);
        chk("rst_ren", sif.mem_ren, 0);
        chk("rst_wen", sif.mem_wen, 0);
        chk("rst_win_valid", sif.win_valid, 0);
        chk("rst_addr", sif.mem_addr, 0);
        chk("rst_wdata", sif.mem_wdata, 0);
        chk("rst_window", sif.window, 0);
        sif.start = 1'b0;
        n_rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("idle_no_start", sif.busy, 0);
        end

        // ramp image, no stalls: exact latencies
        run_frame(0, 1'b0);

        // small-gradient window: gx=3, gy=5
        for (int a = 0; a < 256; a++) img[a] = 8'd0;
        img[1*W + 2] = 8'd1;
        img[2*W + 1] = 8'd2;
        img[2*W + 2] = 8'd1;
        run_frame(0, 1'b0);
        chk("small_mag", first_wdata, 8);

        // strong vertical edge saturates
        for (int a = 0; a < 256; a++) img[a] = ((a % W) >= 2) ? 8'd200 : 8'd0;
        run_frame(0, 1'b0);
        chk("sat_mag", first_wdata, 255);

        // random images with random stalls
        repeat (3) begin
            rand_img();
            run_frame(40, 1'b0);
        end

        // reset during the second write
        rand_img();
        @(negedge clk);
        sif.start = 1'b1;
        wcnt = 0;
        for (int k = 0; k < 200 && wcnt < 2; k++) begin
            @(negedge clk);
            sif.start = 1'b0;
            #1;
            if (sif.mem_wen) wcnt++;
        end
        chk("mid_second_write", wcnt, 2);
        n_rst = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_rst_ren", sif.mem_ren, 0);
        chk("mid_rst_wen", sif.mem_wen, 0);
        chk("mid_rst_busy", sif.busy, 0);
        chk("mid_rst_window", sif.window, 0);
        n_rst = 1'b1;
        dcnt = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (sif.done || sif.busy) dcnt++;
        end
        chk("mid_rst_quiet", dcnt, 0);
        run_frame(25, 1'b0);

        // start held high across DONE relaunches immediately
        rand_img();
        run_frame(0, 1'b1);
        sif.start = 1'b0;
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
